fetch_bp: RTL and testbench

- Next-generation fetch/next-PC unit. Replaces the combinational next-PC logic with a registered PC, a stall input and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Parametrised in XLEN and BTB depth.
- The execute stage reports every resolved branch/jump. The block detects a misprediction, redirects the PC and raises flush.
- Sits at the head of the pipeline and drives the instruction-memory address.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_btb.sv | 64 ++++++
 rtl/fetch_bp.sv | 102 ++++++++++
 tb/tb_fetch_bp.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch/next-PC unit: counter encoding, BTB entry
// metadata, default reset PC and saturating counter helpers.
package fetch_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  // Per-entry state that must be cleared on reset; tag and target are
  // width-dependent and live in separate arrays inside the BTB.
  typedef struct packed {
    logic       valid;
    logic [1:0] ctr;
  } btb_meta_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == CTR_ST) ? CTR_ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer: combinational read port, single
// write port applying the resolve-time update, valid/counter clear on rst.
module fetch_btb
  import fetch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-3:0] rd_addr,
  output logic            rd_hit,
  output logic            rd_taken,
  output logic [XLEN-1:0] rd_target,
  input  logic            wr_en,
  input  logic [XLEN-3:0] wr_addr,
  input  logic            wr_taken,
  input  logic [XLEN-1:0] wr_target
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  btb_meta_t        meta_q [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_q  [BTB_ENTRIES];
  logic [XLEN-1:0]  tgt_q  [BTB_ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_hit;

  assign rd_idx    = rd_addr[IDX_W-1:0];
  assign rd_hit    = meta_q[rd_idx].valid && (tag_q[rd_idx] == rd_addr[XLEN-3:IDX_W]);
  assign rd_taken  = rd_hit && meta_q[rd_idx].ctr[1];
  assign rd_target = tgt_q[rd_idx];

  assign wr_idx = wr_addr[IDX_W-1:0];
  assign wr_tag = wr_addr[XLEN-3:IDX_W];
  assign wr_hit = meta_q[wr_idx].valid && (tag_q[wr_idx] == wr_tag);

  // Reads above see the pre-update contents; writes land at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        meta_q[i] <= '0;
      end
    end else if (wr_en) begin
      if (wr_taken) begin
        tgt_q[wr_idx] <= wr_target;
        if (wr_hit) begin
          meta_q[wr_idx].ctr <= sat_inc(meta_q[wr_idx].ctr);
        end else begin
          meta_q[wr_idx].valid <= 1'b1;
          meta_q[wr_idx].ctr   <= CTR_WT;
          tag_q[wr_idx]        <= wr_tag;
        end
      end else if (wr_hit) begin
        meta_q[wr_idx].ctr <= sat_dec(meta_q[wr_idx].ctr);
      end
    end
  end

endmodule

// File: rtl/fetch_bp.sv
// Fetch/next-PC unit: registered PC, BTB-based prediction, misprediction
// detection and redirect. Optional perf counters under FETCH_BP_PERF_EN.
module fetch_bp
  import fetch_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(DEF_RESET_PC),
  parameter int              BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            res_valid,
  input  logic [XLEN-1:0] res_pc,
  input  logic            res_taken,
  input  logic [XLEN-1:0] res_target,
  input  logic            res_pred_taken,
  input  logic [XLEN-1:0] res_pred_target,
  output logic            flush,
  output logic [31:0]     perf_ctrl_cnt,
  output logic [31:0]     perf_mispred_cnt
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] correct_pc;
  logic [XLEN-1:0] btb_target;
  logic            btb_hit;
  logic            btb_taken;
  logic            mispredict;

  fetch_btb #(
    .XLEN       (XLEN),
    .BTB_ENTRIES(BTB_ENTRIES)
  ) u_btb (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (pc_q[XLEN-1:2]),
    .rd_hit   (btb_hit),
    .rd_taken (btb_taken),
    .rd_target(btb_target),
    .wr_en    (res_valid),
    .wr_addr  (res_pc[XLEN-1:2]),
    .wr_taken (res_taken),
    .wr_target({res_target[XLEN-1:1], 1'b0})
  );

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + XLEN'(4);
  assign pred_taken  = btb_taken;
  assign pred_target = btb_hit ? btb_target : pc_plus4;

  // Target mismatch only matters when the branch was actually taken.
  assign mispredict = res_valid &&
                      ((res_taken != res_pred_taken) ||
                       (res_taken && (res_target != res_pred_target)));
  assign flush      = mispredict;
  assign correct_pc = res_taken ? res_target : res_pc + XLEN'(4);

  always_comb begin
    next_pc = pc_q;
    if (mispredict) begin
      next_pc = correct_pc;
    end else if (!stall) begin
      next_pc = pred_taken ? pred_target : pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= next_pc;
    end
  end

`ifdef FETCH_BP_PERF_EN
  logic [31:0] ctrl_cnt_q;
  logic [31:0] mispred_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_cnt_q    <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (res_valid) ctrl_cnt_q <= ctrl_cnt_q + 32'd1;
      if (mispredict) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign perf_ctrl_cnt    = ctrl_cnt_q;
  assign perf_mispred_cnt = mispred_cnt_q;
`else
  assign perf_ctrl_cnt    = '0;
  assign perf_mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_bp.sv
// Randomized and directed bench for fetch_bp against an array-based model
// of the predictor rules.
module tb_fetch_bp;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic        flush;
  logic [31:0] perf_ctrl_cnt;
  logic [31:0] perf_mispred_cnt;

  int checks = 0;
  int errors = 0;

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_bp dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .pc              (pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .res_valid       (res_valid),
    .res_pc          (res_pc),
    .res_taken       (res_taken),
    .res_target      (res_target),
    .res_pred_taken  (res_pred_taken),
    .res_pred_target (res_pred_target),
    .flush           (flush),
    .perf_ctrl_cnt   (perf_ctrl_cnt),
    .perf_mispred_cnt(perf_mispred_cnt)
  );

  // Reference model: plain arrays indexed by word address modulo depth
  bit          m_ok = 0;
  logic [31:0] m_pc;
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int unsigned m_ctrl_cnt;
  int unsigned m_mis_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_hit(input logic [31:0] a);
    int idx;
    idx = int'((a / 4) % 16);
    return m_valid[idx] && (m_tag[idx] == a / 64);
  endfunction

  function automatic logic [31:0] m_pred_target(input logic [31:0] a);
    if (m_hit(a)) return m_tgt[int'((a / 4) % 16)];
    return a + 32'd4;
  endfunction

  function automatic bit m_pred_taken(input logic [31:0] a);
    return m_hit(a) && (m_ctr[int'((a / 4) % 16)] >= 2);
  endfunction

  function automatic bit m_mispred();
    if (!res_valid) return 0;
    if (res_taken != res_pred_taken) return 1;
    return res_taken && (res_target != res_pred_target);
  endfunction

  // Driver: apply one cycle of inputs, check outputs mid-cycle, then advance
  // the model at the clock edge.
  task automatic cycle(input logic s, input logic r, input logic rv, input logic [31:0] rpc,
                       input logic rt, input logic [31:0] rtg, input logic rpt,
                       input logic [31:0] rptg);
    bit          mis;
    bit          ptk;
    logic [31:0] ptg;
    int          idx;
    stall = s; rst = r; res_valid = rv; res_pc = rpc; res_taken = rt;
    res_target = rtg; res_pred_taken = rpt; res_pred_target = rptg;
    #1;
    mis = m_mispred();
    if (m_ok) begin
      ptk = m_pred_taken(m_pc);
      ptg = m_pred_target(m_pc);
      check("pc", pc, m_pc);
      check("pred_taken", {31'd0, pred_taken}, {31'd0, ptk});
      check("pred_target", pred_target, ptg);
      check("flush", {31'd0, flush}, {31'd0, mis});
`ifdef FETCH_BP_PERF_EN
      check("perf_ctrl", perf_ctrl_cnt, m_ctrl_cnt);
      check("perf_mispred", perf_mispred_cnt, m_mis_cnt);
`else
      check("perf_ctrl", perf_ctrl_cnt, 32'd0);
      check("perf_mispred", perf_mispred_cnt, 32'd0);
`endif
    end else begin
      ptk = 0;
      ptg = '0;
    end
    @(posedge clk);
    if (r) begin
      m_ok = 1;
      m_pc = 32'h0;
      m_ctrl_cnt = 0;
      m_mis_cnt = 0;
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 0;
        m_ctr[i] = 0;
      end
    end else if (m_ok) begin
      if (rv) begin
        m_ctrl_cnt++;
        idx = int'((rpc / 4) % 16);
        if (rt) begin
          if (m_hit(rpc)) begin
            m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
          end else begin
            m_valid[idx] = 1;
            m_tag[idx] = rpc / 64;
            m_ctr[idx] = 2;
          end
          m_tgt[idx] = rtg & ~32'd1;
        end else if (m_hit(rpc)) begin
          m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
        end
      end
      if (mis) begin
        m_mis_cnt++;
        m_pc = rt ? rtg : rpc + 32'd4;
      end else if (!s) begin
        m_pc = ptk ? ptg : m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, 0, '0, 0, '0);
  endtask

  task automatic resolve(input logic s, input logic [31:0] rpc, input logic rt,
                         input logic [31:0] rtg, input logic rpt, input logic [31:0] rptg);
    cycle(s, 0, 1, rpc, rt, rtg, rpt, rptg);
  endtask

  // Redirect fetch to address a via a not-taken branch at a-4 predicted taken.
  task automatic go_to(input logic [31:0] a);
    resolve(0, a - 32'd4, 0, '0, 1, '0);
  endtask

  initial begin
    logic [31:0] rpc, rtg, rptg;
    logic        rt, rpt, rv, s, r;
    cycle(0, 1, 0, '0, 0, '0, 0, '0);
    cycle(0, 1, 0, '0, 0, '0, 0, '0);
    check("reset_pc", pc, 32'h0);
    idle(4);

    // Allocate 0x10 -> 0x40
    cycle(0, 0, 1, 32'h10, 1, 32'h40, 0, 32'h0);
    check("alloc_pc", pc, 32'h40);
    go_to(32'h10);
    check("hit_taken", {31'd0, pred_taken}, 32'd1);
    check("hit_target", pred_target, 32'h40);

    // Two not-taken resolves walk the counter down
    resolve(0, 32'h10, 0, '0, 1, '0);
    check("nt1_pc", pc, 32'h14);
    resolve(0, 32'h10, 0, '0, 0, '0);
    go_to(32'h10);
    check("nt_pred", {31'd0, pred_taken}, 32'd0);
    idle(1);
    check("nt_next", pc, 32'h14);

    // Mispredict overrides stall; stall alone holds
    resolve(1, 32'h20, 0, '0, 1, '0);
    check("stall_redir", pc, 32'h24);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, '0, 0, '0, 0, '0);
    check("stall_hold", pc, 32'h24);

    // JALR with odd target stores cleared bit0; retarget mispredicts once
    resolve(0, 32'h30, 1, 32'h101, 0, '0);
    go_to(32'h30);
    check("jalr_tgt", pred_target, 32'h100);
    resolve(0, 32'h30, 1, 32'h200, 1, 32'h100);
    go_to(32'h30);
    check("retarget", pred_target, 32'h200);

    // PC wrap
    resolve(0, 32'h50, 1, 32'hFFFF_FFFC, 0, '0);
    check("wrap_pre", pc, 32'hFFFF_FFFC);
    idle(1);
    check("wrap", pc, 32'h0);

    // Reset during redirect clears pc and BTB
    cycle(0, 1, 1, 32'h10, 1, 32'h80, 0, '0);
    check("rst_pc", pc, 32'h0);
    idle(5);

    // Perf window: 5 resolves, 2 mispredicts
    cycle(0, 1, 0, '0, 0, '0, 0, '0);
    resolve(1, 32'h300, 0, '0, 0, '0);
    resolve(1, 32'h304, 1, 32'h500, 0, '0);
    resolve(0, 32'h308, 0, '0, 0, '0);
    resolve(0, 32'h30C, 1, 32'h600, 1, 32'h700);
    resolve(0, 32'h310, 0, '0, 0, '0);
    idle(1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 2))
        0: rpc = 32'($urandom_range(0, 31)) * 4;
        1: rpc = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
        default: rpc = 32'hFFFF_FF00 + 32'($urandom_range(0, 63)) * 4;
      endcase
      rt   = $urandom_range(0, 1);
      rtg  = $urandom & 32'hFFFF_0FFC;
      rpt  = ($urandom_range(0, 3) == 0) ? ~rt : rt;
      rptg = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : rtg;
      if (!rv) rpc = '0;
      cycle(s, r, rv, rpc, rt, rtg, rpt, rptg);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
